// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: sequences direct, base-relative and indirect loads and
// stores against a data memory whose read port is combinational from Data_addr.
`timescale 1ns/1ps
module mem_access_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] aluout,
    input  logic [15:0] M_Data,
    input  logic [15:0] Data_dout,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_rd,
    output logic [15:0] memout,
    output logic        mem_busy,
    output logic        mem_done
);

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IND   = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] memout_q, memout_d;
    logic        mem_done_q, mem_done_d;

    logic [3:0]  opcode;
    logic        is_mem_op;
    logic [1:0]  entry_state;
    logic        ir_unused;

    assign opcode    = IR_Exec[15:12];
    assign ir_unused = ^IR_Exec[11:0];

    // Opcode decode: which state an accepted instruction enters first.
    always_comb begin
        is_mem_op   = 1'b1;
        entry_state = S_IDLE;
        case (opcode)
            OP_LD, OP_LDR:  entry_state = S_READ;
            OP_ST, OP_STR:  entry_state = S_WRITE;
            OP_LDI, OP_STI: entry_state = S_IND;
            default:        is_mem_op   = 1'b0;
        endcase
    end

    // NOTE: every variable gets a hold/default value before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        memout_d   = memout_q;
        mem_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_execute && is_mem_op) begin
                    addr_d  = aluout;
                    data_d  = M_Data;
                    op_d    = opcode;
                    state_d = entry_state;
                end
            end
            S_IND: begin
                // The pointer fetched this cycle replaces the address, whatever its value.
                addr_d  = Data_dout;
                state_d = (op_q == OP_LDI) ? S_READ : S_WRITE;
            end
            S_READ: begin
                memout_d   = Data_dout;
                mem_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_WRITE: begin
                mem_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            op_q       <= 4'h0;
            memout_q   <= 16'h0000;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_q       <= op_d;
            memout_q   <= memout_d;
            mem_done_q <= mem_done_d;
        end
    end

    // Memory-port outputs depend on state and registers only, so reset forces them idle at once.
    always_comb begin
        Data_addr = 16'h0000;
        Data_din  = 16'h0000;
        Data_rd   = 1'b1;
        case (state_q)
            S_IND, S_READ: Data_addr = addr_q;
            S_WRITE: begin
                Data_addr = addr_q;
                Data_din  = data_q;
                Data_rd   = 1'b0;
            end
            default: ;
        endcase
    end

    assign memout   = memout_q;
    assign mem_done = mem_done_q;
    assign mem_busy = (state_q != S_IDLE);

endmodule
